// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIF pair feeder.
// Twiddles are round(1024*cos), round(-1024*sin) of 2*pi*k/N for k = 0..N/2-1.
package fft_pkg;

  localparam int DW      = 12;
  localparam int TW_FRAC = 10;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_e;

  localparam int TW8_RE [4] = '{1024, 724, 0, -724};
  localparam int TW8_IM [4] = '{0, -724, -1024, -724};

  localparam int TW16_RE [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
  localparam int TW16_IM [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};

  localparam int TW32_RE [16] = '{
    1024, 1004, 946, 851, 724, 569, 392, 200,
    0, -200, -392, -569, -724, -851, -946, -1004};
  localparam int TW32_IM [16] = '{
    0, -200, -392, -569, -724, -851, -946, -1004,
    -1024, -1004, -946, -851, -724, -569, -392, -200};

  localparam int TW64_RE [32] = '{
    1024, 1019, 1004, 980, 946, 903, 851, 792,
    724, 650, 569, 483, 392, 297, 200, 100,
    0, -100, -200, -297, -392, -483, -569, -650,
    -724, -792, -851, -903, -946, -980, -1004, -1019};
  localparam int TW64_IM [32] = '{
    0, -100, -200, -297, -392, -483, -569, -650,
    -724, -792, -851, -903, -946, -980, -1004, -1019,
    -1024, -1019, -1004, -980, -946, -903, -851, -792,
    -724, -650, -569, -483, -392, -297, -200, -100};

endpackage

// File: rtl/fft_pair_feeder_if.sv
// Sample stream in, butterfly operand pair out. The master drives samples,
// the slave (feeder) drives the registered butterfly operands.
interface fft_pair_feeder_if #(
  parameter int DW = 12,
  parameter int N  = 8
);
  localparam int KW = $clog2(N) - 1;

  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] x1_r;
  logic signed [DW-1:0] x1_i;
  logic signed [DW-1:0] x2_r;
  logic signed [DW-1:0] x2_i;
  logic signed [DW-1:0] w_r;
  logic signed [DW-1:0] w_i;
  logic                 pair_valid;
  logic [KW-1:0]        pair_idx;
  logic                 sof_err;

  modport master (
    output in_valid, in_sof, in_r, in_i,
    input  x1_r, x1_i, x2_r, x2_i, w_r, w_i, pair_valid, pair_idx, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_i,
    output x1_r, x1_i, x2_r, x2_i, w_r, w_i, pair_valid, pair_idx, sof_err
  );

endinterface

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup W_N^k for k = 0..N/2-1.
// Any N other than 8/16/32 falls through to the 64-point table.
module fft_twiddle_rom #(
  parameter int N  = 8,
  parameter int DW = 12
) (
  input  logic [$clog2(N)-2:0] k_i,
  output logic signed [DW-1:0] w_r_o,
  output logic signed [DW-1:0] w_i_o
);
  import fft_pkg::*;

  if (N == 8) begin : g_n8
    assign w_r_o = TW8_RE[k_i][DW-1:0];
    assign w_i_o = TW8_IM[k_i][DW-1:0];
  end else if (N == 16) begin : g_n16
    assign w_r_o = TW16_RE[k_i][DW-1:0];
    assign w_i_o = TW16_IM[k_i][DW-1:0];
  end else if (N == 32) begin : g_n32
    assign w_r_o = TW32_RE[k_i][DW-1:0];
    assign w_i_o = TW32_IM[k_i][DW-1:0];
  end else begin : g_n64
    assign w_r_o = TW64_RE[k_i][DW-1:0];
    assign w_i_o = TW64_IM[k_i][DW-1:0];
  end

endmodule

// File: rtl/fft_pair_feeder.sv
// Buffers the first half of each frame and presents (x1, x2, w) pairs
// to the downstream butterfly one cycle after each second-half sample.
//
//   state | meaning
//   FILL  | writing first-half sample cnt into the buffer
//   PAIR  | pairing second-half sample with buffered sample cnt
module fft_pair_feeder #(
  parameter int N  = 8,
  parameter int DW = 12
) (
  input logic              clk,
  input logic              rst_n,
  fft_pair_feeder_if.slave bus
);
  import fft_pkg::*;

  localparam int KW   = $clog2(N) - 1;
  localparam int HALF = N / 2;

  state_e               state_q, state_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] x1_r_q, x1_r_d, x1_i_q, x1_i_d;
  logic signed [DW-1:0] x2_r_q, x2_r_d, x2_i_q, x2_i_d;
  logic signed [DW-1:0] w_r_q, w_r_d, w_i_q, w_i_d;
  logic [KW-1:0]        pair_idx_q, pair_idx_d;
  logic                 pair_valid_q, pair_valid_d;
  logic                 sof_err_q, sof_err_d;

  logic signed [DW-1:0] mem_r_q [HALF];
  logic signed [DW-1:0] mem_i_q [HALF];
  logic                 mem_we;
  logic [KW-1:0]        mem_wa;

  logic signed [DW-1:0] tw_r, tw_i;
  logic                 last, resync;

  fft_twiddle_rom #(.N(N), .DW(DW)) u_rom (
    .k_i   (cnt_q),
    .w_r_o (tw_r),
    .w_i_o (tw_i)
  );

  assign last   = &cnt_q;
  // sof is only legitimate at the very start of FILL; anywhere else restarts the frame
  assign resync = bus.in_valid && bus.in_sof && !(state_q == FILL && cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x1_r_d       = x1_r_q;
    x1_i_d       = x1_i_q;
    x2_r_d       = x2_r_q;
    x2_i_d       = x2_i_q;
    w_r_d        = w_r_q;
    w_i_d        = w_i_q;
    pair_idx_d   = pair_idx_q;
    pair_valid_d = 1'b0;
    sof_err_d    = 1'b0;
    mem_we       = 1'b0;
    mem_wa       = cnt_q;
    if (bus.in_valid) begin
      if (resync) begin
        mem_we    = 1'b1;
        mem_wa    = '0;
        state_d   = FILL;
        cnt_d     = KW'(1);
        sof_err_d = 1'b1;
      end else if (state_q == FILL) begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + KW'(1);
        if (last) state_d = PAIR;
      end else begin
        x1_r_d       = mem_r_q[cnt_q];
        x1_i_d       = mem_i_q[cnt_q];
        x2_r_d       = bus.in_r;
        x2_i_d       = bus.in_i;
        w_r_d        = tw_r;
        w_i_d        = tw_i;
        pair_idx_d   = cnt_q;
        pair_valid_d = 1'b1;
        cnt_d        = cnt_q + KW'(1);
        if (last) state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      x1_r_q       <= '0;
      x1_i_q       <= '0;
      x2_r_q       <= '0;
      x2_i_q       <= '0;
      w_r_q        <= '0;
      w_i_q        <= '0;
      pair_idx_q   <= '0;
      pair_valid_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x1_r_q       <= x1_r_d;
      x1_i_q       <= x1_i_d;
      x2_r_q       <= x2_r_d;
      x2_i_q       <= x2_i_d;
      w_r_q        <= w_r_d;
      w_i_q        <= w_i_d;
      pair_idx_q   <= pair_idx_d;
      pair_valid_q <= pair_valid_d;
      sof_err_q    <= sof_err_d;
    end
  end

  // Buffer is never read before being rewritten, so it needs no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_r_q[mem_wa] <= bus.in_r;
      mem_i_q[mem_wa] <= bus.in_i;
    end
  end

  assign bus.x1_r       = x1_r_q;
  assign bus.x1_i       = x1_i_q;
  assign bus.x2_r       = x2_r_q;
  assign bus.x2_i       = x2_i_q;
  assign bus.w_r        = w_r_q;
  assign bus.w_i        = w_i_q;
  assign bus.pair_idx   = pair_idx_q;
  assign bus.pair_valid = pair_valid_q;
  assign bus.sof_err    = sof_err_q;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Scoreboard bench for fft_pair_feeder (N = 8): stimulus pushes expected pairs
// and sof_err pulses with their due cycle; a negedge monitor pops and compares.
module tb_fft_pair_feeder;

  typedef logic signed [11:0] smp_t;
  typedef smp_t frame_t [8];
  typedef struct {
    int         cyc;
    smp_t       x1r, x1i, x2r, x2i, wr, wi;
    logic [1:0] idx;
  } exp_t;

  localparam int TWR [4] = '{1024, 724, 0, -724};
  localparam int TWI [4] = '{0, -724, -1024, -724};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q [$];
  int   sof_q [$];
  exp_t e;
  int   sc;

  fft_pair_feeder_if #(.DW(12), .N(8)) bus ();

  fft_pair_feeder #(.N(8), .DW(12)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, compares content and arrival cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pair_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pair: idx=%0d at cycle %0d, none expected", bus.pair_idx, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || bus.x1_r !== e.x1r || bus.x1_i !== e.x1i ||
              bus.x2_r !== e.x2r || bus.x2_i !== e.x2i || bus.w_r !== e.wr ||
              bus.w_i !== e.wi || bus.pair_idx !== e.idx) begin
            miscompares++;
            $display("FAIL pair: got cyc=%0d x1=(%0d,%0d) x2=(%0d,%0d) w=(%0d,%0d) idx=%0d expected cyc=%0d x1=(%0d,%0d) x2=(%0d,%0d) w=(%0d,%0d) idx=%0d",
                     cyc, bus.x1_r, bus.x1_i, bus.x2_r, bus.x2_i, bus.w_r, bus.w_i, bus.pair_idx,
                     e.cyc, e.x1r, e.x1i, e.x2r, e.x2i, e.wr, e.wi, e.idx);
          end
        end
      end
      if (bus.sof_err) begin
        vectors++;
        if (sof_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_sof_err: at cycle %0d, none expected", cyc);
        end else begin
          sc = sof_q.pop_front();
          if (sc != cyc) begin
            miscompares++;
            $display("FAIL sof_err_cycle: got %0d expected %0d", cyc, sc);
          end
        end
      end
    end
  end

  task automatic drive(input smp_t r, input smp_t i, input logic v, input logic sof);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_r     = r;
    bus.in_i     = i;
  endtask

  // Idle cycles carry random data and sof, which must be ignored.
  task automatic idle(input int n);
    repeat (n) drive(smp_t'($urandom), smp_t'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic push_pair(input frame_t fr, input frame_t fi, input int k);
    exp_t x;
    x.cyc = cyc + 1;
    x.x1r = fr[k];
    x.x1i = fi[k];
    x.x2r = fr[k+4];
    x.x2i = fi[k+4];
    x.wr  = smp_t'(TWR[k]);
    x.wi  = smp_t'(TWI[k]);
    x.idx = 2'(k);
    exp_q.push_back(x);
  endtask

  task automatic frame(input frame_t fr, input frame_t fi, input logic sof0,
                       input logic err, input int gap_mask);
    for (int j = 0; j < 8; j++) begin
      if (gap_mask[j]) idle(1 + $urandom_range(0, 2));
      drive(fr[j], fi[j], 1'b1, sof0 && (j == 0));
      if (j == 0 && err) sof_q.push_back(cyc + 1);
      if (j >= 4) push_pair(fr, fi, j - 4);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.x1_r, bus.x1_i, bus.x2_r, bus.x2_i, bus.w_r, bus.w_i,
                 bus.pair_idx, bus.pair_valid, bus.sof_err}, '0);
  endtask

  frame_t ar, ai, br, bi, cr, ci, dr, di, er, ei, fr, fi, xr, xi, gr, gi, hr, hi;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;
    for (int j = 0; j < 8; j++) begin
      ar[j] = smp_t'(j + 1);         ai[j] = smp_t'(-(j + 1));
      br[j] = smp_t'(100 + j);       bi[j] = smp_t'(200 + 3 * j);
      cr[j] = smp_t'(-300 - j);      ci[j] = smp_t'(50 * j);
      dr[j] = smp_t'(37 * j - 500);  di[j] = smp_t'(1000 - 111 * j);
      er[j] = smp_t'(400 + j);       ei[j] = smp_t'(-400 - j);
      fr[j] = smp_t'(-(10 * j + 7)); fi[j] = smp_t'(20 * j + 3);
      xr[j] = (j < 4) ? smp_t'(2047) : smp_t'(-2048);
      xi[j] = (j < 4) ? smp_t'(-2048) : smp_t'(2047);
      gr[j] = smp_t'(5 * j + 11);    gi[j] = smp_t'(-(7 * j + 13));
      hr[j] = smp_t'(600 - 3 * j);   hi[j] = smp_t'(9 * j - 50);
    end

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      drive(smp_t'($urandom), smp_t'($urandom), 1'($urandom), 1'($urandom));
      check_zero("reset_outputs");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // First frame after reset needs no sof
    frame(ar, ai, 1'b0, 1'b0, 0);
    // Three back-to-back frames
    frame(br, bi, 1'b1, 1'b0, 0);
    frame(cr, ci, 1'b1, 1'b0, 0);
    frame(dr, di, 1'b1, 1'b0, 0);
    // Gaps, including between samples 3 and 4
    frame(ar, ai, 1'b1, 1'b0, 32'b0001_1010);
    frame(br, bi, 1'b0, 1'b0, 32'b1110_0001);

    // Resync: sof at sample 5 of a frame
    for (int j = 0; j < 5; j++) begin
      drive(er[j], ei[j], 1'b1, 1'b0);
      if (j == 4) push_pair(er, ei, 0);
    end
    frame(fr, fi, 1'b1, 1'b1, 0);

    // Extremes pass through bit-exact
    frame(xr, xi, 1'b1, 1'b0, 0);

    // Reset in PAIR after two pairs
    for (int j = 0; j < 6; j++) begin
      drive(gr[j], gi[j], 1'b1, 1'b0);
      if (j >= 4) push_pair(gr, gi, j - 4);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_pair");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_mid_hold");
    rst_n = 1'b1;
    frame(hr, hi, 1'b0, 1'b0, 0);

    idle(4);
    check("pairs_outstanding", 128'(exp_q.size()), 128'(0));
    check("sof_err_outstanding", 128'(sof_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
